// File: rtl/coin_pkg.sv
// Coin denominations and payout FSM state encoding, shared with maincontroller.
package coin_pkg;

  localparam logic [1:0] PENNY   = 2'b00;
  localparam logic [1:0] NICKEL  = 2'b01;
  localparam logic [1:0] DIME    = 2'b10;
  localparam logic [1:0] QUARTER = 2'b11;

  localparam logic [4:0] PENNY_CENTS   = 5'd1;
  localparam logic [4:0] NICKEL_CENTS  = 5'd5;
  localparam logic [4:0] DIME_CENTS    = 5'd10;
  localparam logic [4:0] QUARTER_CENTS = 5'd25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_RELEASE,
    S_DONE,
    S_FAULT
  } state_e;

endpackage

// File: rtl/change_coin_select.sv
// Greedy picker: largest coin whose value does not exceed the amount still owed.
module change_coin_select
  import coin_pkg::*;
(
  input  logic [6:0] remaining,
  output logic [1:0] coin,
  output logic [4:0] value
);

  always_comb begin
    coin  = PENNY;
    value = PENNY_CENTS;
    if (remaining >= 7'(QUARTER_CENTS)) begin
      coin  = QUARTER;
      value = QUARTER_CENTS;
    end else if (remaining >= 7'(DIME_CENTS)) begin
      coin  = DIME;
      value = DIME_CENTS;
    end else if (remaining >= 7'(NICKEL_CENTS)) begin
      coin  = NICKEL;
      value = NICKEL_CENTS;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time over a req/ack handshake with the
// coin-eject mechanism; faults if an acknowledge never arrives.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] amount,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  input  logic       coin_ack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [6:0] remaining,
  output logic [3:0] coins_out
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  state_e      state_q, state_d;
  logic        coin_req_q, coin_req_d;
  logic [1:0]  coin_sel_q, coin_sel_d;
  logic [4:0]  value_q, value_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [6:0]  remaining_q, remaining_d;
  logic [3:0]  coins_out_q, coins_out_d;
  logic [CW-1:0] wait_q, wait_d;

  logic [1:0]  pick_coin;
  logic [4:0]  pick_value;

  change_coin_select u_select (
    .remaining (remaining_q),
    .coin      (pick_coin),
    .value     (pick_value)
  );

  always_comb begin
    state_d     = state_q;
    coin_req_d  = coin_req_q;
    coin_sel_d  = coin_sel_q;
    value_d     = value_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    remaining_d = remaining_q;
    coins_out_d = coins_out_q;
    wait_d      = wait_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d     = S_SELECT;
          remaining_d = amount;
          coins_out_d = '0;
          error_d     = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_SELECT: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d    = S_REQ;
          coin_sel_d = pick_coin;
          value_d    = pick_value;
          coin_req_d = 1'b1;
          wait_d     = '0;
        end
      end
      S_REQ: begin
        // Acknowledge wins over a timeout landing on the same edge.
        if (coin_ack) begin
          state_d     = S_RELEASE;
          coin_req_d  = 1'b0;
          remaining_d = remaining_q - {2'b00, value_q};
          coins_out_d = coins_out_q + 4'd1;
        end else if (wait_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d    = S_FAULT;
          coin_req_d = 1'b0;
          busy_d     = 1'b0;
          error_d    = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!coin_ack) state_d = S_SELECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      coin_req_q  <= 1'b0;
      coin_sel_q  <= PENNY;
      value_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      remaining_q <= '0;
      coins_out_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      coin_req_q  <= coin_req_d;
      coin_sel_q  <= coin_sel_d;
      value_q     <= value_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      remaining_q <= remaining_d;
      coins_out_q <= coins_out_d;
      wait_q      <= wait_d;
    end
  end

  assign coin_req  = coin_req_q;
  assign coin_sel  = coin_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign remaining = remaining_q;
  assign coins_out = coins_out_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy coin plan queued at start, checked per request.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] amount;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       coin_ack;
  logic       busy;
  logic       done;
  logic       error;
  logic [6:0] remaining;
  logic [3:0] coins_out;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_sel_q[$];
  logic [6:0] exp_rem_q[$];

  change_dispenser #(.ACK_TIMEOUT(8)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .start         (start),
    .amount        (amount),
    .coin_req      (coin_req),
    .coin_sel      (coin_sel),
    .coin_ack      (coin_ack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .remaining     (remaining),
    .coins_out     (coins_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Independent greedy model: queue expected coin codes and remaining-after values.
  task automatic plan(input int amt);
    int r;
    r = amt;
    while (r > 0) begin
      if (r >= 25) begin exp_sel_q.push_back(2'b11); r -= 25; end
      else if (r >= 10) begin exp_sel_q.push_back(2'b10); r -= 10; end
      else if (r >= 5) begin exp_sel_q.push_back(2'b01); r -= 5; end
      else begin exp_sel_q.push_back(2'b00); r -= 1; end
      exp_rem_q.push_back(7'(r));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, coin_req, 0);
    check({tag, "_sel"}, coin_sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_rem"}, remaining, 0);
    check({tag, "_coins"}, coins_out, 0);
  endtask

  // Called at a negedge; returns at the negedge following the start-sampling edge.
  task automatic pulse_start(input logic [6:0] amt);
    start  = 1'b1;
    amount = amt;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_req", coin_req, 0);
    check("start_error", error, 0);
    check("start_rem", remaining, amt);
    check("start_coins", coins_out, 0);
  endtask

  task automatic serve(input int ack_delay, input int hold, input bit poke);
    int n;
    logic [1:0] s;
    logic [6:0] r;
    n = 0;
    while (exp_sel_q.size() > 0) begin
      @(negedge clk);
      s = exp_sel_q.pop_front();
      r = exp_rem_q.pop_front();
      check("req_up", coin_req, 1);
      check("coin_sel", coin_sel, s);
      if (poke && n == 0) begin
        start  = 1'b1;
        amount = 7'd99;
      end
      for (int i = 1; i < ack_delay; i++) begin
        @(negedge clk);
        start = 1'b0;
        check("req_wait", coin_req, 1);
        check("sel_stable", coin_sel, s);
      end
      start    = 1'b0;
      coin_ack = 1'b1;
      @(negedge clk);
      n++;
      check("req_drop", coin_req, 0);
      check("rem_after_ack", remaining, r);
      check("coins_after_ack", coins_out, n);
      check("busy_release", busy, 1);
      repeat (hold) begin
        @(negedge clk);
        check("hold_no_req", coin_req, 0);
        check("hold_busy", busy, 1);
        check("hold_rem", remaining, r);
      end
      coin_ack = 1'b0;
      @(negedge clk);
      check("select_no_req", coin_req, 0);
      check("select_busy", busy, 1);
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_req", coin_req, 0);
    check("done_rem", remaining, 0);
    check("done_coins", coins_out, n);
    @(negedge clk);
    check("done_single", done, 0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    coin_ack = 1'b0;
    amount   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Mixed coins: 41 -> Q D N P
    plan(41);
    pulse_start(7'd41);
    serve(3, 0, 1'b0);

    // Zero amount: done two edges after start, no request
    plan(0);
    pulse_start(7'd0);
    serve(1, 0, 1'b0);

    // Maximum amount: five quarters then two pennies
    plan(127);
    pulse_start(7'd127);
    serve(1, 0, 1'b0);

    // Ack held high in RELEASE; start(99) while busy is ignored
    plan(41);
    pulse_start(7'd41);
    serve(2, 5, 1'b1);

    // Timeout with ACK_TIMEOUT = 8
    pulse_start(7'd127);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("to_req_high", coin_req, 1);
      check("to_no_error", error, 0);
    end
    @(negedge clk);
    check("to_error", error, 1);
    check("to_req_low", coin_req, 0);
    check("to_busy", busy, 0);
    check("to_rem_frozen", remaining, 127);
    check("to_coins_frozen", coins_out, 0);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    check("fault_sticky", error, 1);
    check("fault_ack_ignored", coins_out, 0);
    plan(5);
    pulse_start(7'd5);
    serve(1, 0, 1'b0);

    // Reset asserted mid-REQ takes effect asynchronously
    pulse_start(7'd41);
    @(negedge clk);
    check("pre_reset_req", coin_req, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", busy, 0);
    plan(10);
    pulse_start(7'd10);
    serve(1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
